// File: rtl/key_pkg.sv
// Shared key codes, break prefix and FSM state encoding for the key entry path.
package key_pkg;

    localparam logic [4:0] DIG_MAX    = 5'd15;
    localparam logic [4:0] KEY_ENTER  = 5'd16;
    localparam logic [4:0] KEY_BKSP   = 5'd17;
    localparam logic [4:0] KEY_CLR    = 5'd18;
    localparam logic [4:0] KEY_NONE   = 5'd31;
    localparam logic [7:0] BRK_PREFIX = 8'hF0;

    localparam logic [3:0] MAX_DIGITS = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ENTRY = 2'd1,
        ST_READY = 2'd2
    } key_state_t;

    // True for the hex digit codes 0..15.
    function automatic logic is_digit(input logic [4:0] code);
        return code <= DIG_MAX;
    endfunction

endpackage

// File: rtl/key_event_det.sv
// Turns the level-style key_code into one registered event pulse per key press.
// A press is a transition away from the idle code that is not a break frame
// and carries a defined code (0..18). Codes 19..30 never produce an event.
module key_event_det
    import key_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic [4:0] key_code,
    input  logic [7:0] key_prev,
    output logic       evt,
    output logic [4:0] evt_code
);

    logic [4:0] key_q;
    logic       armed;
    logic       evt_d;

    // A press needs the previous sample to be idle; armed blocks the very
    // first cycle after reset, where key_q is idle only because of reset.
    always_comb begin
        evt_d = armed
             && (key_q == KEY_NONE)
             && (key_code <= KEY_CLR)
             && (key_prev != BRK_PREFIX);
    end

    // Sample the key level and register the event pulse with its code.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            key_q    <= KEY_NONE;
            armed    <= 1'b0;
            evt      <= 1'b0;
            evt_code <= KEY_NONE;
        end else begin
            key_q    <= key_code;
            armed    <= 1'b1;
            evt      <= evt_d;
            evt_code <= key_code;
        end
    end

endmodule

// File: rtl/key_entry_ctrl.sv
// Hex number entry controller: collects up to eight hex digits from key
// events, supports backspace/clear/enter, and holds the result for the CPU
// until it acknowledges the read. State is exported for observation.
module key_entry_ctrl
    import key_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic [4:0]  key_code,
    input  logic [7:0]  key_prev,
    input  logic        cpu_ack,
    output logic [31:0] value,
    output logic        value_valid,
    output logic [3:0]  digit_cnt,
    output logic        ovf,
    output logic        entering,
    output key_state_t  state
);

    logic       evt;
    logic [4:0] evt_code;

    key_event_det u_det (
        .clk      (clk),
        .rstn     (rstn),
        .key_code (key_code),
        .key_prev (key_prev),
        .evt      (evt),
        .evt_code (evt_code)
    );

    // Entry FSM with its datapath; value_valid and entering are registered
    // alongside the state so they always equal (state == READY/ENTRY).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= ST_IDLE;
            value       <= 32'h0;
            digit_cnt   <= 4'd0;
            ovf         <= 1'b0;
            value_valid <= 1'b0;
            entering    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (evt && is_digit(evt_code)) begin
                        value     <= {28'h0, evt_code[3:0]};
                        digit_cnt <= 4'd1;
                        ovf       <= 1'b0;
                        state     <= ST_ENTRY;
                        entering  <= 1'b1;
                    end else if (evt && (evt_code == KEY_CLR)) begin
                        value     <= 32'h0;
                        digit_cnt <= 4'd0;
                        ovf       <= 1'b0;
                    end
                end
                ST_ENTRY: begin
                    if (evt && is_digit(evt_code)) begin
                        if (digit_cnt == MAX_DIGITS) begin
                            ovf <= 1'b1;
                        end else begin
                            value     <= {value[27:0], evt_code[3:0]};
                            digit_cnt <= digit_cnt + 4'd1;
                        end
                    end else if (evt && (evt_code == KEY_BKSP)) begin
                        ovf <= 1'b0;
                        if (digit_cnt == 4'd1) begin
                            // Removing the last digit leaves nothing to edit.
                            value     <= 32'h0;
                            digit_cnt <= 4'd0;
                            state     <= ST_IDLE;
                            entering  <= 1'b0;
                        end else begin
                            value     <= value >> 4;
                            digit_cnt <= digit_cnt - 4'd1;
                        end
                    end else if (evt && (evt_code == KEY_ENTER)) begin
                        state       <= ST_READY;
                        entering    <= 1'b0;
                        value_valid <= 1'b1;
                    end else if (evt && (evt_code == KEY_CLR)) begin
                        value     <= 32'h0;
                        digit_cnt <= 4'd0;
                        ovf       <= 1'b0;
                        state     <= ST_IDLE;
                        entering  <= 1'b0;
                    end
                end
                ST_READY: begin
                    // The CPU read takes priority over any same-cycle key.
                    if (cpu_ack) begin
                        digit_cnt   <= 4'd0;
                        state       <= ST_IDLE;
                        value_valid <= 1'b0;
                    end else if (evt && (evt_code == KEY_CLR)) begin
                        value       <= 32'h0;
                        digit_cnt   <= 4'd0;
                        ovf         <= 1'b0;
                        state       <= ST_IDLE;
                        value_valid <= 1'b0;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    value_valid <= 1'b0;
                    entering    <= 1'b0;
                end
            endcase
        end
    end

endmodule
